// File: rtl/digit_extract_sequencer.sv
// digit_extract_sequencer: walks a shared (number/divider)%mod unit over
// five decades and publishes BCD digits plus a leading-zero blank mask.
module digit_extract_sequencer #(
    parameter int DIV_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] div_number,
    output logic [15:0] div_divider,
    output logic [15:0] div_mod,
    input  logic [3:0]  div_result,
    output logic [19:0] digits,
    output logic [4:0]  blank_mask,
    output logic        err
);
    localparam int CW = (DIV_WAIT > 1) ? $clog2(DIV_WAIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   num;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [19:0]   sh_dig;
    logic          sh_err;
    logic          last;
    logic          publish;
    logic [4:0]    mask_nx;

    assign last    = (cnt == '0);
    assign publish = (state == WAIT) && (state_nx == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (last && idx == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The units digit never blanks, so only the upper four shadow digits matter.
    always_comb begin
        mask_nx    = 5'b00000;
        mask_nx[4] = (sh_dig[19:16] == 4'd0);
        mask_nx[3] = mask_nx[4] && (sh_dig[15:12] == 4'd0);
        mask_nx[2] = mask_nx[3] && (sh_dig[11:8] == 4'd0);
        mask_nx[1] = mask_nx[2] && (sh_dig[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num        <= '0;
            idx        <= '0;
            cnt        <= '0;
            sh_dig     <= '0;
            sh_err     <= 1'b0;
            digits     <= '0;
            blank_mask <= 5'b11110;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        num    <= value;
                        idx    <= 3'd4;
                        cnt    <= RELOAD;
                        sh_err <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!last) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        sh_dig[{idx, 2'b00} +: 4] <= div_result;
                        if (div_result > 4'd9) sh_err <= 1'b1;
                        if (idx != 3'd0) begin
                            idx <= idx - 3'd1;
                            cnt <= RELOAD;
                        end
                    end
                end
                default: ;
            endcase
            // Units digit lands on the same edge, so merge it directly.
            if (publish) begin
                digits     <= {sh_dig[19:4], div_result};
                blank_mask <= mask_nx;
                err        <= sh_err || (div_result > 4'd9);
            end
        end
    end

    always_comb begin
        div_divider = 16'd1;
        if (state == WAIT) begin
            unique case (idx)
                3'd4:    div_divider = 16'd10000;
                3'd3:    div_divider = 16'd1000;
                3'd2:    div_divider = 16'd100;
                3'd1:    div_divider = 16'd10;
                default: div_divider = 16'd1;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign div_number = num;
    assign div_mod    = 16'd10;

endmodule

// File: doc/digit_extract_sequencer.md
Name: digit_extract_sequencer

Overview:
Sequences one shared combinational digit-extraction unit, of the form result = (number/divider) % mod, across the five decimal digits of a 16-bit measured frequency. On a start request it presents divisors 10000, 1000, 100, 10 and 1 in turn. It captures each 4-bit digit and publishes all five BCD digits atomically, with a leading-zero blank mask for the seven-segment display driver. It sits between the frequency counter's latched count and the display multiplexer.

Parameters:
DIV_WAIT, 1, cycles each operand set is held before the result is sampled (>=1; covers extractor combinational/pipeline delay)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request conversion of value; sampled only in IDLE
value  in  16  binary count to convert; latched on accepted start
busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
done  out  1  one-cycle pulse; digits/blank_mask/err valid and updated
div_number  out  16  operand to extractor: latched value
div_divider  out  16  operand to extractor: current decade divisor
div_mod  out  16  operand to extractor: constant 10
div_result  in  4  extractor result for current operands
digits  out  20  BCD; [19:16]=ten-thousands … [3:0]=units
blank_mask  out  5  bit i=1 means digit i is a leading zero to blank
err  out  1  last conversion captured a div_result > 9

Behaviour:
- Clock/reset: one clock, clk; reset synchronous, active-high.
- Reset values: state IDLE, busy=0, done=0, digits=0, blank_mask=5'b11110, err=0, latched value=0, div_divider=1, div_mod=10.
- States: IDLE, WAIT, DONE.
- IDLE: if start=1, latch value, set idx=4, load wait counter to DIV_WAIT-1, clear the shadow err bit, and go to WAIT. Otherwise remain.
- WAIT: drive div_divider = {10000,1000,100,10,1}[4-idx], div_number = latched value, div_mod = 10; operands are stable for exactly DIV_WAIT cycles per digit.
  - Counter not zero: decrement it.
  - Counter zero (last cycle of the digit): write div_result into shadow digit idx; set shadow err if div_result > 9 (the digit is stored unmodified).
    - idx=0: go to DONE.
    - Otherwise: decrement idx and reload counter to DIV_WAIT-1.
- DONE transition: on the edge entering DONE, copy shadow digits to digits, compute blank_mask, and copy shadow err to err.
- DONE state: done=1 for one cycle, then IDLE.
- Outputs are registered: digits, blank_mask and err change only on entry to DONE and hold until the next completion. A partial conversion is never visible.
- In IDLE: div_number holds the last latched value, div_divider=1.
- Latency: start accepted at edge k gives busy=1 in cycles k+1 … k+1+5·DIV_WAIT, and done=1 in cycle k+1+5·DIV_WAIT. With DIV_WAIT=1: done 6 cycles after the start edge; the next start is accepted at the following cycle (IDLE).
- start while busy (WAIT or DONE) is ignored, not queued. A change of value during conversion has no effect.
- blank_mask: bit i (i=4..1) = 1 iff digits 4 down to i are all zero. Bit 0 is always 0 (units never blanked).
- Reset mid-conversion aborts at the next edge: all outputs return to their reset values, and no done pulse follows.
- Widths: divisor constants are 16-bit; 10000 fits. Max value 65535 gives 6,5,5,3,5.

Test Plan:
- Reset, then DIV_WAIT=1 with a behavioural extractor model; start with value=54231 -> done exactly 6 cycles after the start edge; digits=20'h54231, blank_mask=5'b00000, err=0; busy high for cycles 1–6.
- value=0 -> digits=20'h00000, blank_mask=5'b11110; value=705 -> digits=20'h00705, blank_mask=5'b11000.
- DIV_WAIT=3, value=65535, start held high throughout -> each divisor (10000,1000,100,10,1) held exactly 3 cycles; done at cycle 16; digits=20'h65535; one done per conversion, next start accepted only in IDLE.
- Reset asserted in cycle 3 of a conversion for value=12345 -> next cycle busy=0, digits=0, blank_mask=5'b11110; no done pulse afterwards; fresh start then completes normally.
- Extractor model forced to return 12 on the tens step -> done with err=1 and digits[7:4]=4'hC; next conversion with a correct model clears err=0.
- Value 100 converted, then value 9 -> digits update only at each done; between pulses digits stay 20'h00100 with blank_mask=5'b11000; after the second done, digits=20'h00009 with blank_mask=5'b11110.
